// File: rtl/wb_cmd_pkg.sv
// -----------------------------------------------------------------------------
// wb_cmd_pkg
// Shared types for the multi-channel command-to-WISHBONE master.
//   rsp_status_t : completion status returned with every response
//   state_t      : master FSM states
//   clog2_min1   : index width helper that never returns zero (safe for N=1)
// -----------------------------------------------------------------------------
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_ERR     = 2'd1,
        RSP_RTY     = 2'd2,
        RSP_TIMEOUT = 2'd3
    } rsp_status_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TXN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_cmd_arb_master_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: the first requester at or after the
// pointer wins, wrapping to the lowest index when nothing at/after it requests.
// Ports:
//   req_i   [N]   request vector
//   ptr_i   [IW]  index with highest priority this round
//   grant_o [N]   one-hot grant (zero when no request)
//   idx_o   [IW]  binary index of the grant
//   valid_o       any request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import wb_cmd_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // First pass covers indices at/after the pointer, second pass is the wrap.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!valid_o && req_i[c] && (IW'(c) >= ptr_i)) begin
                valid_o    = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!valid_o && req_i[c]) begin
                valid_o    = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/wb_cmd_arb_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_arb_master
// Round-robin arbitrates NUM_CH command streams onto one WISHBONE classic
// master port, one bus cycle per command, retrying on RTY up to MAX_RETRY
// times and returning data plus status to the requesting channel.
// Optional feature macro: WB_CMD_ARB_TIMEOUT_EN builds the TXN timeout counter
// (abort after TIMEOUT_CYCLES cycles without termination, status RSP_TIMEOUT).
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, synchronous active-low reset
//   cmd_addr_i / cmd_data_i     per-channel {rnw, addr} and write data
//   cmd_valid_i / cmd_ack_o     per-channel request / one-cycle capture pulse
//   rsp_data_o / rsp_status_o   response payload, held until next response
//   rsp_valid_o                 one-hot one-cycle response pulse
//   busy_o                      FSM not idle
//   wb_*                        WISHBONE classic master signals
// -----------------------------------------------------------------------------
module wb_cmd_arb_master
    import wb_cmd_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADR_W          = 22,
    parameter int DAT_W          = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    input  logic [NUM_CH*(ADR_W+1)-1:0] cmd_addr_i,
    input  logic [NUM_CH*DAT_W-1:0]     cmd_data_i,
    input  logic [NUM_CH-1:0]           cmd_valid_i,
    output logic [NUM_CH-1:0]           cmd_ack_o,
    output logic [DAT_W-1:0]            rsp_data_o,
    output rsp_status_t                 rsp_status_o,
    output logic [NUM_CH-1:0]           rsp_valid_o,
    output logic                        busy_o,
    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic [ADR_W-1:0]            wb_adr_o,
    output logic [DAT_W-1:0]            wb_dat_o,
    output logic                        wb_we_o,
    output logic [DAT_W/8-1:0]          wb_sel_o,
    input  logic [DAT_W-1:0]            wb_dat_i,
    input  logic                        wb_ack_i,
    input  logic                        wb_err_i,
    input  logic                        wb_rty_i
);

    localparam int IW = clog2_min1(NUM_CH);
    localparam int RW = clog2_min1(MAX_RETRY + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DAT_W-1:0]  dat_q, dat_d;
    logic              rnw_q, rnw_d;
    logic [RW-1:0]     retry_q, retry_d;
    rsp_status_t       status_q, status_d;
    logic [DAT_W-1:0]  rsp_data_q, rsp_data_d;
    logic [NUM_CH-1:0] cmd_ack_q, cmd_ack_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;
    logic [ADR_W:0]    sel_cmd;
    logic [DAT_W-1:0]  sel_data;
    logic              expired;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req_i   (cmd_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Mux the granted channel's command fields out of the flat input buses.
    always_comb begin
        sel_cmd  = '0;
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_grant[c]) begin
                sel_cmd  = cmd_addr_i[c*(ADR_W+1) +: (ADR_W+1)];
                sel_data = cmd_data_i[c*DAT_W +: DAT_W];
            end
        end
    end

`ifdef WB_CMD_ARB_TIMEOUT_EN
    localparam int TW = clog2_min1(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d;

    // Counts cycles of the current strobe; cleared outside TXN so each
    // retry attempt gets a fresh budget, and rolls over on expiry.
    always_comb begin
        tmo_d = '0;
        if (state_q == TXN && !expired) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign expired = (state_q == TXN) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    // Timeout logic not built: constant-false (TIMEOUT_CYCLES is always >= 2).
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state logic. Termination priority inside TXN is err > ack > rty,
    // and a real termination on the expiry cycle beats the timeout.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rnw_d      = rnw_q;
        retry_d    = retry_q;
        status_d   = status_q;
        rsp_data_d = rsp_data_q;
        cmd_ack_d  = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d          = TXN;
                    grant_d          = arb_idx;
                    {rnw_d, adr_d}   = sel_cmd;
                    dat_d            = sel_data;
                    retry_d          = '0;
                    cmd_ack_d        = arb_grant;
                end
            end
            TXN: begin
                if (wb_err_i) begin
                    state_d  = DONE;
                    status_d = RSP_ERR;
                end else if (wb_ack_i) begin
                    state_d  = DONE;
                    status_d = RSP_OK;
                end else if (wb_rty_i) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        state_d = GAP;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        state_d  = DONE;
                        status_d = RSP_RTY;
                    end
                end else if (expired) begin
                    state_d  = DONE;
                    status_d = RSP_TIMEOUT;
                end
                // Writes always echo their data; reads only update on ack.
                if (state_d == DONE) begin
                    if (!rnw_q) begin
                        rsp_data_d = dat_q;
                    end else if (!wb_err_i && wb_ack_i) begin
                        rsp_data_d = wb_dat_i;
                    end
                end
            end
            GAP: begin
                state_d = TXN;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rnw_q      <= 1'b0;
            retry_q    <= '0;
            status_q   <= RSP_OK;
            rsp_data_q <= '0;
            cmd_ack_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rnw_q      <= rnw_d;
            retry_q    <= retry_d;
            status_q   <= status_d;
            rsp_data_q <= rsp_data_d;
            cmd_ack_q  <= cmd_ack_d;
        end
    end

    assign wb_cyc_o     = (state_q == TXN);
    assign wb_stb_o     = (state_q == TXN);
    assign wb_we_o      = (state_q == TXN) && !rnw_q;
    assign wb_sel_o     = {(DAT_W/8){wb_we_o}};
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign cmd_ack_o    = cmd_ack_q;
    assign rsp_valid_o  = (state_q == DONE) ? (NUM_CH'(1) << grant_q) : '0;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = status_q;
    assign busy_o       = (state_q != IDLE);

endmodule
